// File: rtl/tug_round_ctrl.sv
// rtl/tug_round_ctrl.sv - tug-of-war round/match sequencer; optional FALSE_START_EN macro enables false-start forfeits
module tug_round_ctrl #(
    parameter int COUNT_TICKS = 3,
    parameter int SHOW_TICKS  = 4,
    parameter int WIN_ROUNDS  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slowen,
    input  logic       start,
    input  logic       pb_left,
    input  logic       pb_right,
    output logic [6:0] pos_leds,
    output logic       over,
    output logic       winright,
    output logic [1:0] score_l,
    output logic [1:0] score_r,
    output logic       match_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNTDN,
        S_PLAY,
        S_SHOW,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD  = 4'(COUNT_TICKS);
    localparam logic [3:0] SHOW_LOAD = 4'(SHOW_TICKS);
    localparam logic [1:0] WIN_SCORE = 2'(WIN_ROUNDS);
    localparam logic [2:0] POS_MID   = 3'd3;

    state_t     state_q, state_d;
    logic [2:0] pos_q, pos_d;
    logic [3:0] cnt_q, cnt_d;
    logic       over_d, winright_d;
    logic [1:0] score_l_d, score_r_d;
    logic       busy_d, match_done_d;
    logic       fs_forfeit, fs_reload;

`ifdef FALSE_START_EN
    assign fs_forfeit = pb_left ^ pb_right;
    assign fs_reload  = pb_left & pb_right;
`else
    assign fs_forfeit = 1'b0;
    assign fs_reload  = 1'b0;
`endif

    // Next-state logic: countdown, rope movement, win detection and score keeping
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        over_d     = over;
        winright_d = winright;
        score_l_d  = score_l;
        score_r_d  = score_r;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CNTDN;
                    cnt_d   = CNT_LOAD;
                    pos_d   = POS_MID;
                end
            end
            S_CNTDN: begin
                if (fs_forfeit) begin
                    // a lone early press hands the round to the opponent
                    state_d    = S_SHOW;
                    over_d     = 1'b1;
                    winright_d = pb_left;
                    cnt_d      = SHOW_LOAD;
                    if (pb_left) score_r_d = score_r + 2'd1;
                    else         score_l_d = score_l + 2'd1;
                end else if (fs_reload) begin
                    cnt_d = CNT_LOAD;
                end else if (slowen) begin
                    if (cnt_q == 4'd1) state_d = S_PLAY;
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_PLAY: begin
                if (pb_left && !pb_right) begin
                    pos_d = pos_q + 3'd1;
                    if (pos_q == 3'd5) begin
                        state_d    = S_SHOW;
                        over_d     = 1'b1;
                        winright_d = 1'b0;
                        score_l_d  = score_l + 2'd1;
                        cnt_d      = SHOW_LOAD;
                    end
                end else if (pb_right && !pb_left) begin
                    pos_d = pos_q - 3'd1;
                    if (pos_q == 3'd1) begin
                        state_d    = S_SHOW;
                        over_d     = 1'b1;
                        winright_d = 1'b1;
                        score_r_d  = score_r + 2'd1;
                        cnt_d      = SHOW_LOAD;
                    end
                end
            end
            S_SHOW: begin
                if (slowen) begin
                    if (cnt_q == 4'd1) begin
                        over_d = 1'b0;
                        pos_d  = POS_MID;
                        if ((winright ? score_r : score_l) == WIN_SCORE) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CNTDN;
                            cnt_d   = CNT_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    score_l_d = 2'd0;
                    score_r_d = 2'd0;
                    state_d   = S_CNTDN;
                    cnt_d     = CNT_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d       = (state_d == S_CNTDN) || (state_d == S_PLAY) || (state_d == S_SHOW);
        match_done_d = (state_d == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pos_q      <= POS_MID;
            cnt_q      <= 4'd0;
            pos_leds   <= 7'b0001000;
            over       <= 1'b0;
            winright   <= 1'b0;
            score_l    <= 2'd0;
            score_r    <= 2'd0;
            match_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
            pos_leds   <= 7'b0000001 << pos_d;
            over       <= over_d;
            winright   <= winright_d;
            score_l    <= score_l_d;
            score_r    <= score_r_d;
            match_done <= match_done_d;
            busy       <= busy_d;
        end
    end

endmodule
